// File: rtl/smg_scan_arbiter.sv
// Digit-scan sequencer and two-requester data arbiter for a 4-digit seven-segment decoder.
// Words from A (normal) and B (overlay) are buffered and committed only at frame boundaries.
module smg_scan_arbiter #(
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic [1:0]  bitsel,
  output logic [15:0] data,
  output logic        frame_tick,
  output logic        overlay_active
);

  typedef enum logic [0:0] {
    SHOW_A = 1'b0,
    SHOW_B = 1'b1
  } state_t;

  localparam logic [20:0] PRESC_MAX = 21'(PRESCALE - 1);
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD_FRAMES - 1);

  state_t      state_r;
  logic [20:0] presc_r;
  logic [7:0]  hold_r;
  logic [15:0] a_cur_r;
  logic [15:0] a_pend_r;
  logic [15:0] b_pend_r;
  logic        a_pend_v_r;
  logic        b_pend_v_r;

  logic        tick_s;
  logic        frame_end_s;
  logic        a_acc_s;
  logic        b_acc_s;

  assign tick_s      = (presc_r == PRESC_MAX);
  assign frame_end_s = tick_s && (bitsel == 2'd3);
  assign a_ready     = !a_pend_v_r;
  assign b_ready     = !b_pend_v_r;
  assign a_acc_s     = a_valid && !a_pend_v_r;
  assign b_acc_s     = b_valid && !b_pend_v_r;

  // Slot prescaler: counts 0..PRESCALE-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= 21'd0;
    end else if (tick_s) begin
      presc_r <= 21'd0;
    end else begin
      presc_r <= presc_r + 21'd1;
    end
  end

  // Digit scan and frame-end pulse, which lines up with bitsel returning to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitsel     <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end_s;
      if (tick_s) begin
        bitsel <= bitsel + 2'd1;
      end
    end
  end

  // Input buffering plus the frame-boundary commit FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= SHOW_A;
      data           <= 16'h0000;
      a_cur_r        <= 16'h0000;
      a_pend_r       <= 16'h0000;
      b_pend_r       <= 16'h0000;
      a_pend_v_r     <= 1'b0;
      b_pend_v_r     <= 1'b0;
      hold_r         <= 8'd0;
      overlay_active <= 1'b0;
    end else begin
      // A slot can only accept while empty, so a commit never collides with a fresh accept.
      if (a_acc_s) begin
        a_pend_r   <= a_data;
        a_pend_v_r <= 1'b1;
      end
      if (b_acc_s) begin
        b_pend_r   <= b_data;
        b_pend_v_r <= 1'b1;
      end
      if (frame_end_s) begin
        case (state_r)
          SHOW_A: begin
            if (b_pend_v_r) begin
              data           <= b_pend_r;
              b_pend_v_r     <= 1'b0;
              hold_r         <= HOLD_INIT;
              state_r        <= SHOW_B;
              overlay_active <= 1'b1;
            end else if (a_pend_v_r) begin
              data       <= a_pend_r;
              a_cur_r    <= a_pend_r;
              a_pend_v_r <= 1'b0;
            end
          end
          SHOW_B: begin
            if (b_pend_v_r) begin
              data       <= b_pend_r;
              b_pend_v_r <= 1'b0;
              hold_r     <= HOLD_INIT;
            end else if (hold_r == 8'd0) begin
              if (a_pend_v_r) begin
                data       <= a_pend_r;
                a_cur_r    <= a_pend_r;
                a_pend_v_r <= 1'b0;
              end else begin
                data <= a_cur_r;
              end
              state_r        <= SHOW_A;
              overlay_active <= 1'b0;
            end else begin
              hold_r <= hold_r - 8'd1;
            end
          end
          default: begin
            state_r        <= SHOW_A;
            overlay_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smg_scan_arbiter.sv
// Directed bench for smg_scan_arbiter with PRESCALE=4 (16-cycle frames) and HOLD_FRAMES=2.
// n counts clock edges since reset release; edge n with n%16==15 is the frame_end cycle.
module tb_smg_scan_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [15:0] b_data;
  logic        b_ready;
  logic [1:0]  bitsel;
  logic [15:0] data;
  logic        frame_tick;
  logic        overlay_active;

  int n_cmp;
  int n_mis;
  int n;

  smg_scan_arbiter #(.PRESCALE(4), .HOLD_FRAMES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a_valid        (a_valid),
    .a_data         (a_data),
    .a_ready        (a_ready),
    .b_valid        (b_valid),
    .b_data         (b_data),
    .b_ready        (b_ready),
    .bitsel         (bitsel),
    .data           (data),
    .frame_tick     (frame_tick),
    .overlay_active (overlay_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s at n=%0d: got %h, expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n = n + 1;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_bitsel"}, 32'(bitsel), 32'd0);
    check_value({tag, "_data"}, 32'(data), 32'h0000);
    check_value({tag, "_ftick"}, 32'(frame_tick), 32'd0);
    check_value({tag, "_ovl"}, 32'(overlay_active), 32'd0);
    check_value({tag, "_a_rdy"}, 32'(a_ready), 32'd1);
    check_value({tag, "_b_rdy"}, 32'(b_ready), 32'd1);
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    n       = 0;
    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_data  = 16'h0000;
    b_valid = 1'b0;
    b_data  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Scan pattern: bitsel advances every 4 edges, frame_tick every 16 edges at bitsel=0.
    for (int i = 1; i <= 32; i++) begin
      step();
      check_value("scan_bitsel", 32'(bitsel), 32'((n / 4) % 4));
      check_value("scan_ftick", 32'(frame_tick), (n % 16 == 0) ? 32'd1 : 32'd0);
    end
    check_value("idle_data", 32'(data), 32'h0000);
    check_value("idle_a_rdy", 32'(a_ready), 32'd1);

    // A write mid-frame: buffered until frame_end.
    run_to(36);
    a_valid = 1'b1; a_data = 16'h1234;
    step();
    a_valid = 1'b0;
    check_value("a1_rdy_low", 32'(a_ready), 32'd0);
    check_value("a1_hold_data", 32'(data), 32'h0000);
    run_to(47);
    check_value("a1_pre_commit", 32'(data), 32'h0000);
    step();
    check_value("a1_commit", 32'(data), 32'h1234);
    check_value("a1_rdy_high", 32'(a_ready), 32'd1);

    // A write accepted exactly in the frame_end cycle commits a frame later.
    run_to(63);
    a_valid = 1'b1; a_data = 16'h2468;
    step();
    a_valid = 1'b0;
    check_value("a2_not_yet", 32'(data), 32'h1234);
    check_value("a2_rdy_low", 32'(a_ready), 32'd0);
    run_to(80);
    check_value("a2_commit", 32'(data), 32'h2468);
    check_value("a2_rdy_high", 32'(a_ready), 32'd1);

    // Overlay: 2 full frames of E001, then back to the A word.
    run_to(84);
    b_valid = 1'b1; b_data = 16'hE001;
    step();
    b_valid = 1'b0;
    check_value("b1_rdy_low", 32'(b_ready), 32'd0);
    check_value("b1_ovl_pre", 32'(overlay_active), 32'd0);
    run_to(96);
    check_value("b1_data", 32'(data), 32'hE001);
    check_value("b1_ovl", 32'(overlay_active), 32'd1);
    check_value("b1_rdy_high", 32'(b_ready), 32'd1);
    run_to(127);
    check_value("b1_still", 32'(data), 32'hE001);
    step();
    check_value("b1_expire_data", 32'(data), 32'h2468);
    check_value("b1_expire_ovl", 32'(overlay_active), 32'd0);

    // A words during overlay: 5678 buffered, 9ABC stalls until the overlay ends.
    run_to(132);
    b_valid = 1'b1; b_data = 16'hE002;
    step();
    b_valid = 1'b0;
    run_to(148);
    check_value("b2_data", 32'(data), 32'hE002);
    a_valid = 1'b1; a_data = 16'h5678;
    step();
    a_data = 16'h9ABC;
    check_value("a3_rdy_low", 32'(a_ready), 32'd0);
    run_to(175);
    check_value("a3_stall_rdy", 32'(a_ready), 32'd0);
    check_value("a3_stall_data", 32'(data), 32'hE002);
    step();
    check_value("a3_commit", 32'(data), 32'h5678);
    check_value("a3_ovl_off", 32'(overlay_active), 32'd0);
    check_value("a3_rdy_high", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    check_value("a4_accepted", 32'(a_ready), 32'd0);
    run_to(192);
    check_value("a4_commit", 32'(data), 32'h9ABC);

    // A and B pending together: B wins, A waits; B rewrite restarts the hold.
    run_to(196);
    a_valid = 1'b1; a_data = 16'h1357;
    b_valid = 1'b1; b_data = 16'hE003;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    run_to(208);
    check_value("ab_b_wins", 32'(data), 32'hE003);
    check_value("ab_a_pending", 32'(a_ready), 32'd0);
    run_to(225);
    b_valid = 1'b1; b_data = 16'hE004;
    step();
    b_valid = 1'b0;
    run_to(240);
    check_value("b_rewrite", 32'(data), 32'hE004);
    run_to(256);
    check_value("hold_restart", 32'(data), 32'hE004);
    check_value("hold_restart_ovl", 32'(overlay_active), 32'd1);
    run_to(272);
    check_value("ab_a_shows", 32'(data), 32'h1357);
    check_value("ab_ovl_off", 32'(overlay_active), 32'd0);
    check_value("ab_a_rdy", 32'(a_ready), 32'd1);

    // Asynchronous reset mid-overlay at bitsel=2, with a B word pending.
    run_to(276);
    b_valid = 1'b1; b_data = 16'hE005;
    step();
    b_valid = 1'b0;
    run_to(290);
    b_valid = 1'b1; b_data = 16'hE006;
    step();
    b_valid = 1'b0;
    run_to(296);
    check_value("pre_rst_data", 32'(data), 32'hE005);
    check_value("pre_rst_bitsel", 32'(bitsel), 32'd2);
    check_value("pre_rst_b_rdy", 32'(b_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check_value("rescan_bitsel", 32'(bitsel), 32'((n / 4) % 4));
      check_value("rescan_data", 32'(data), 32'h0000);
      check_value("rescan_ovl", 32'(overlay_active), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
